// File: rtl/wb_line_cache_pkg.sv
// ============================================================================
// wb_line_cache_pkg : shared line/address/select types and cache FSM state
// Revision 1.0
// ============================================================================
`default_nettype none

package wb_line_cache_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [15:0]  lc3b_byte_sel;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    RESPOND   = 2'd3
  } wb_cache_state_t;

  localparam lc3b_byte_sel SEL_ALL = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/wb_line_cache_cache_array.sv
// ============================================================================
// wb_line_cache_cache_array : direct-mapped storage {valid,dirty,tag,line}
// Async read by index, sync write with per-byte line enables. Revision 1.0
// ============================================================================
`default_nettype none

module wb_line_cache_cache_array
  import wb_line_cache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [TAG_W-1:0] tag_o,
  output lc3b_line         line_o,
  input  lc3b_byte_sel     line_be_i,
  input  lc3b_line         line_i,
  input  logic             tag_we_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             valid_set_i,
  input  logic             dirty_we_i,
  input  logic             dirty_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  lc3b_line            line_q [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_set_i) valid_q[idx_i] <= 1'b1;
      if (dirty_we_i)  dirty_q[idx_i] <= dirty_i;
    end
  end

  // Tag and data storage carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= tag_i;
    for (int b = 0; b < 16; b++) begin
      if (line_be_i[b]) line_q[idx_i][8*b +: 8] <= line_i[8*b +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_line_cache.sv
// ============================================================================
// wb_line_cache : direct-mapped write-back cache, wishbone slave to CPU,
// wishbone master to pmem. Optional WB_LINE_CACHE_PERF_EN adds hit/miss counters.
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_line_cache
  import wb_line_cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cyc_i,
  input  logic          cpu_stb_i,
  input  logic          cpu_we_i,
  input  lc3b_line_addr cpu_adr_i,
  input  lc3b_byte_sel  cpu_sel_i,
  input  lc3b_line      cpu_dat_i,
  output lc3b_line      cpu_dat_o,
  output logic          cpu_ack_o,
  output logic          cpu_rty_o,
  output logic          pmem_cyc_o,
  output logic          pmem_stb_o,
  output logic          pmem_we_o,
  output lc3b_line_addr pmem_adr_o,
  output lc3b_byte_sel  pmem_sel_o,
  output lc3b_line      pmem_dat_o,
  input  lc3b_line      pmem_dat_i,
  input  logic          pmem_ack_i,
  input  logic          pmem_rty_i,
  output logic [31:0]   hit_count_o,
  output logic [31:0]   miss_count_o
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  wb_cache_state_t state_q, state_d;
  lc3b_line_addr   adr_q;
  logic            we_q;
  lc3b_byte_sel    sel_q;
  lc3b_line        dat_q;
  logic            rty_q;

  logic             w_req;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             arr_valid, arr_dirty;
  logic [TAG_W-1:0] arr_tag;
  lc3b_line         arr_line;
  lc3b_byte_sel     arr_be;
  lc3b_line         arr_wdata;
  logic             arr_tag_we, arr_valid_set, arr_dirty_we, arr_dirty_d;

  assign w_req     = cpu_cyc_i & cpu_stb_i;
  // In IDLE the live address drives the lookup; afterwards the latched one does.
  assign w_idx     = (state_q == IDLE) ? cpu_adr_i[IDX_W-1:0] : adr_q[IDX_W-1:0];
  assign w_hit     = arr_valid & (arr_tag == cpu_adr_i[11:IDX_W]);
  assign cpu_rty_o = 1'b0;

  wb_line_cache_cache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (w_idx),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .line_o      (arr_line),
    .line_be_i   (arr_be),
    .line_i      (arr_wdata),
    .tag_we_i    (arr_tag_we),
    .tag_i       (adr_q[11:IDX_W]),
    .valid_set_i (arr_valid_set),
    .dirty_we_i  (arr_dirty_we),
    .dirty_i     (arr_dirty_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        adr_q <= cpu_adr_i;
        we_q  <= cpu_we_i;
        sel_q <= cpu_sel_i;
        dat_q <= cpu_dat_i;
      end
      // A retry drops STB for exactly one cycle; ACK takes priority over RTY.
      rty_q <= pmem_stb_o & pmem_rty_i & ~pmem_ack_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_hit)                      state_d = RESPOND;
          else if (arr_valid & arr_dirty) state_d = WRITEBACK;
          else                            state_d = FILL;
        end
      end
      WRITEBACK: if (pmem_stb_o & pmem_ack_i) state_d = FILL;
      FILL:      if (pmem_stb_o & pmem_ack_i) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack_o     = 1'b0;
    cpu_dat_o     = '0;
    pmem_cyc_o    = 1'b0;
    pmem_stb_o    = 1'b0;
    pmem_we_o     = 1'b0;
    pmem_adr_o    = '0;
    pmem_sel_o    = '0;
    pmem_dat_o    = '0;
    arr_be        = '0;
    arr_wdata     = '0;
    arr_tag_we    = 1'b0;
    arr_valid_set = 1'b0;
    arr_dirty_we  = 1'b0;
    arr_dirty_d   = 1'b0;
    case (state_q)
      WRITEBACK: begin
        pmem_cyc_o = 1'b1;
        pmem_stb_o = ~rty_q;
        pmem_we_o  = 1'b1;
        pmem_adr_o = {arr_tag, adr_q[IDX_W-1:0]};
        pmem_sel_o = SEL_ALL;
        pmem_dat_o = arr_line;
        if (pmem_stb_o & pmem_ack_i) begin
          arr_dirty_we = 1'b1;
          arr_dirty_d  = 1'b0;
        end
      end
      FILL: begin
        pmem_cyc_o = 1'b1;
        pmem_stb_o = ~rty_q;
        pmem_adr_o = adr_q;
        pmem_sel_o = SEL_ALL;
        if (pmem_stb_o & pmem_ack_i) begin
          arr_be        = SEL_ALL;
          arr_wdata     = pmem_dat_i;
          arr_tag_we    = 1'b1;
          arr_valid_set = 1'b1;
          arr_dirty_we  = 1'b1;
          arr_dirty_d   = 1'b0;
        end
      end
      RESPOND: begin
        // An aborted requester gets neither ACK nor a write merge.
        if (cpu_cyc_i) begin
          cpu_ack_o = 1'b1;
          cpu_dat_o = arr_line;
          if (we_q) begin
            arr_be       = sel_q;
            arr_wdata    = dat_q;
            arr_dirty_we = 1'b1;
            arr_dirty_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef WB_LINE_CACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == IDLE) begin
      if (state_d == RESPOND && hit_q != 32'hFFFF_FFFF)
        hit_q <= hit_q + 32'd1;
      if ((state_d == WRITEBACK || state_d == FILL) && miss_q != 32'hFFFF_FFFF)
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_line_cache.sv
// ============================================================================
// tb_wb_line_cache : directed self-checking bench for wb_line_cache
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_line_cache;

`ifdef WB_LINE_CACHE_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_cyc = 1'b0, cpu_stb = 1'b0, cpu_we = 1'b0;
  logic [11:0]  cpu_adr = '0;
  logic [15:0]  cpu_sel = '0;
  logic [127:0] cpu_dat_m = '0;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack, cpu_rty;
  logic         pm_cyc, pm_stb, pm_we;
  logic [11:0]  pm_adr;
  logic [15:0]  pm_sel;
  logic [127:0] pm_dat_m;
  logic [127:0] pm_dat_s = '0;
  logic         pm_ack = 1'b0, pm_rty = 1'b0;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  wb_line_cache #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_cyc_i    (cpu_cyc),
    .cpu_stb_i    (cpu_stb),
    .cpu_we_i     (cpu_we),
    .cpu_adr_i    (cpu_adr),
    .cpu_sel_i    (cpu_sel),
    .cpu_dat_i    (cpu_dat_m),
    .cpu_dat_o    (cpu_dat_s),
    .cpu_ack_o    (cpu_ack),
    .cpu_rty_o    (cpu_rty),
    .pmem_cyc_o   (pm_cyc),
    .pmem_stb_o   (pm_stb),
    .pmem_we_o    (pm_we),
    .pmem_adr_o   (pm_adr),
    .pmem_sel_o   (pm_sel),
    .pmem_dat_o   (pm_dat_m),
    .pmem_dat_i   (pm_dat_s),
    .pmem_ack_i   (pm_ack),
    .pmem_rty_i   (pm_rty),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  // pmem responder: ACK after LAT strobed cycles, optional single RTY.
  localparam int LAT = 3;
  logic [127:0] mem [4096];
  int           wait_cnt = 0;
  bit           rty_req = 1'b0;
  bit           rty_done = 1'b0;
  int           pm_wr_cnt = 0, pm_rd_cnt = 0, cyc_cycles = 0, stb_gap = 0;
  logic [11:0]  last_wr_adr = '0, last_rd_adr = '0;
  logic [127:0] last_wr_dat = '0;
  logic [15:0]  last_sel = '0;

  always @(posedge clk) begin
    pm_ack <= 1'b0;
    pm_rty <= 1'b0;
    if (pm_cyc) cyc_cycles <= cyc_cycles + 1;
    if (pm_cyc && !pm_stb) stb_gap <= stb_gap + 1;
    if (pm_cyc && pm_stb && !pm_ack && !pm_rty) begin
      if (rty_req && !rty_done && wait_cnt == 1) begin
        pm_rty   <= 1'b1;
        rty_done <= 1'b1;
        wait_cnt <= 0;
      end else if (wait_cnt == LAT - 1) begin
        pm_ack   <= 1'b1;
        wait_cnt <= 0;
        last_sel <= pm_sel;
        if (pm_we) begin
          mem[pm_adr] <= pm_dat_m;
          last_wr_adr <= pm_adr;
          last_wr_dat <= pm_dat_m;
          pm_wr_cnt   <= pm_wr_cnt + 1;
        end else begin
          pm_dat_s    <= mem[pm_adr];
          last_rd_adr <= pm_adr;
          pm_rd_cnt   <= pm_rd_cnt + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else if (!pm_cyc) begin
      wait_cnt <= 0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; holds the request until ACK, then one idle cycle.
  task automatic cpu_req(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                         input logic [127:0] dat, output logic [127:0] rd, output int n);
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = we;
    cpu_adr = adr; cpu_sel = sel; cpu_dat_m = dat;
    n  = 0;
    rd = '0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (cpu_ack !== 1'b1 && n < 50);
    chk("ack_seen", {127'd0, cpu_ack}, 128'd1);
    rd = cpu_dat_s;
    @(posedge clk); #1;
    chk("ack_single_cycle", {127'd0, cpu_ack}, 128'd0);
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [127:0] rd;
  logic [127:0] exp010;
  int           n;
  int           cyc_before, rd_before, wr_before;
  bit           ack_any;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {8{i[15:0]}};
    mem[12'h010] = {16{8'hA5}};
    mem[12'h018] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    mem[12'h020] = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
    mem[12'h028] = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    mem[12'h033] = 128'h13579BDF_2468ACE0_FEEDFACE_BAADC0DE;
    exp010 = {{14{8'hA5}}, 16'h1234};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", {127'd0, cpu_ack}, 128'd0);
    chk("rst_cpu_dat", cpu_dat_s, 128'd0);
    chk("rst_cpu_rty", {127'd0, cpu_rty}, 128'd0);
    chk("rst_pm_ctl", {125'd0, pm_cyc, pm_stb, pm_we}, 128'd0);
    chk("rst_pm_adr_sel", {100'd0, pm_adr, pm_sel}, 128'd0);
    chk("rst_pm_dat", pm_dat_m, 128'd0);
    chk("rst_counters", {64'd0, hit_count, miss_count}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1 cold read miss
    cpu_req(1'b0, 12'h010, 16'h0000, '0, rd, n);
    chk("t1_data", rd, {16{8'hA5}});
    chk("t1_latency", 128'(n), 128'd5);
    chk("t1_pm_reads", 128'(pm_rd_cnt), 128'd1);
    chk("t1_pm_rd_adr", {116'd0, last_rd_adr}, 128'h010);
    chk("t1_pm_sel", {112'd0, last_sel}, 128'hFFFF);
    chk("t1_miss_count", {96'd0, miss_count}, 128'(PERF));

    // T2 read hit
    cyc_before = cyc_cycles;
    cpu_req(1'b0, 12'h010, 16'h0000, '0, rd, n);
    chk("t2_data", rd, {16{8'hA5}});
    chk("t2_latency", 128'(n), 128'd1);
    chk("t2_no_pmem", 128'(cyc_cycles - cyc_before), 128'd0);
    chk("t2_hit_count", {96'd0, hit_count}, 128'(PERF));

    // T3 partial write then read back
    cpu_req(1'b1, 12'h010, 16'h0003, {{14{8'hFF}}, 16'h1234}, rd, n);
    chk("t3_wr_pre_data", rd, {16{8'hA5}});
    chk("t3_wr_latency", 128'(n), 128'd1);
    cpu_req(1'b0, 12'h010, 16'h0000, '0, rd, n);
    chk("t3_rd_merged", rd, exp010);
    chk("t3_no_pmem", 128'(cyc_cycles - cyc_before), 128'd0);
    chk("t3_hit_count", {96'd0, hit_count}, 128'(3 * PERF));

    // T4 conflicting tag on a dirty line: writeback then fill
    cpu_req(1'b0, 12'h018, 16'h0000, '0, rd, n);
    chk("t4_wb_adr", {116'd0, last_wr_adr}, 128'h010);
    chk("t4_wb_dat", last_wr_dat, exp010);
    chk("t4_pm_writes", 128'(pm_wr_cnt), 128'd1);
    chk("t4_rd_adr", {116'd0, last_rd_adr}, 128'h018);
    chk("t4_data", rd, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("t4_latency", 128'(n), 128'd9);

    // T5 retry during fill of a clean line
    rty_req = 1'b1;
    cpu_req(1'b0, 12'h020, 16'h0000, '0, rd, n);
    chk("t5_data", rd, 128'hDEADBEEF_CAFEF00D_11223344_55667788);
    chk("t5_stb_gap", 128'(stb_gap), 128'd1);
    chk("t5_latency", 128'(n), 128'd9);
    chk("t5_pm_writes", 128'(pm_wr_cnt), 128'd1);
    chk("t5_counts", {64'd0, hit_count, miss_count}, {64'd0, 32'(3 * PERF), 32'(3 * PERF)});

    // T6 reset in the second fill cycle
    rd_before = pm_rd_cnt;
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h010;
    @(posedge clk); #1;
    chk("t6_fill_cyc", {127'd0, pm_cyc}, 128'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_pm_cyc_drop", {127'd0, pm_cyc}, 128'd0);
    chk("t6_counters_clr", {64'd0, hit_count, miss_count}, 128'd0);
    rst = 1'b0;
    cpu_cyc = 1'b0; cpu_stb = 1'b0;
    @(posedge clk); #1;
    cpu_req(1'b0, 12'h010, 16'h0000, '0, rd, n);
    chk("t6_miss_latency", 128'(n), 128'd5);
    chk("t6_data", rd, exp010);
    chk("t6_pm_reads", 128'(pm_rd_cnt - rd_before), 128'd1);

    // SEL=0 write still marks the line dirty
    cpu_req(1'b1, 12'h010, 16'h0000, {16{8'hFF}}, rd, n);
    chk("sel0_latency", 128'(n), 128'd1);
    cpu_req(1'b0, 12'h010, 16'h0000, '0, rd, n);
    chk("sel0_unchanged", rd, exp010);
    wr_before = pm_wr_cnt;
    cpu_req(1'b0, 12'h028, 16'h0000, '0, rd, n);
    chk("sel0_writeback", 128'(pm_wr_cnt - wr_before), 128'd1);
    chk("sel0_wb_dat", last_wr_dat, exp010);
    chk("sel0_new_data", rd, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);

    // Abort mid-miss: fill completes, no ACK, next access hits
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = 12'h033;
    cpu_sel = 16'hFFFF; cpu_dat_m = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    ack_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (cpu_ack === 1'b1) ack_any = 1'b1;
    end
    chk("abort_no_ack", {127'd0, ack_any}, 128'd0);
    cpu_req(1'b0, 12'h033, 16'h0000, '0, rd, n);
    chk("abort_filled_hit", 128'(n), 128'd1);
    chk("abort_no_merge", rd, 128'h13579BDF_2468ACE0_FEEDFACE_BAADC0DE);
    chk("final_counts", {64'd0, hit_count, miss_count}, {64'd0, 32'(3 * PERF), 32'(3 * PERF)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
